led_driver: RTL and testbench

- Five-output LED pattern generator for the board's LED bank (LED0..LED4).
- A 2-bit mode input selects one of four patterns: static, blink, chase or bounce.
- An internal prescaler sets the animation rate by dividing the system clock.
- Sits at top level, directly driving board LED pins; it has no handshake with other logic.

---
 rtl/led_driver.sv | 90 +++++++++
 tb/tb_led_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// Five-LED pattern generator: static, blink, chase and bounce animations
// advanced by a clock prescaler; LEDs decode from registered state only.
module led_driver #(
    parameter int         DIV     = 12000000,
    parameter logic [4:0] PATTERN = 5'b11111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic { UP = 1'b0, DOWN = 1'b1 } dir_t;

    typedef struct packed {
        logic [1:0]    mode;
        logic [CW-1:0] cnt;
        logic          phase;
        logic [2:0]    pos;
        dir_t          dir;
    } state_t;

    localparam state_t ST_INIT = '{mode: 2'd0, cnt: '0, phase: 1'b1, pos: 3'd0, dir: UP};

    state_t     st_q, st_d;
    logic       tick;
    logic [4:0] leds;

    always_ff @(posedge clk) begin
        if (rst) st_q <= ST_INIT;
        else     st_q <= st_d;
    end

    always_comb begin
        tick     = (st_q.cnt == CNT_MAX);
        st_d     = st_q;
        st_d.cnt = tick ? '0 : st_q.cnt + CW'(1);
        // A fresh mode sample restarts the animation and prescaler, overriding any tick.
        if (mode != st_q.mode) begin
            st_d      = ST_INIT;
            st_d.mode = mode;
        end else if (tick) begin
            case (st_q.mode)
                2'd1: st_d.phase = ~st_q.phase;
                2'd2: st_d.pos   = (st_q.pos == 3'd4) ? 3'd0 : st_q.pos + 3'd1;
                2'd3: begin
                    if (st_q.dir == UP) begin
                        if (st_q.pos == 3'd4) begin
                            st_d.dir = DOWN;
                            st_d.pos = 3'd3;
                        end else begin
                            st_d.pos = st_q.pos + 3'd1;
                        end
                    end else begin
                        if (st_q.pos == 3'd0) begin
                            st_d.dir = UP;
                            st_d.pos = 3'd1;
                        end else begin
                            st_d.pos = st_q.pos - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        leds = '0;
        case (st_q.mode)
            2'd0:    leds = PATTERN;
            2'd1:    leds = {5{st_q.phase}};
            default: leds = 5'b00001 << st_q.pos;
        endcase
    end

    assign LED0 = leds[0];
    assign LED1 = leds[1];
    assign LED2 = leds[2];
    assign LED3 = leds[3];
    assign LED4 = leds[4];

endmodule

// File: tb/tb_led_driver.sv
// Scoreboard bench for led_driver with DIV=4: expected images are queued
// as each cycle is driven and compared once that cycle's edge has passed.
module tb_led_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       LED0, LED1, LED2, LED3, LED4;
    logic [4:0] leds;
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    int         total = 0;
    int         bad   = 0;

    int bounce_seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    led_driver #(.DIV(4), .PATTERN(5'b11111)) dut (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .LED0(LED0),
        .LED1(LED1),
        .LED2(LED2),
        .LED3(LED3),
        .LED4(LED4)
    );

    always #5 clk = ~clk;
    assign leds = {LED4, LED3, LED2, LED1, LED0};

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b11111);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, leds, exp_v);
            end
        end
        rst  = 1'b0;
        mode = 2'd0;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(5'b11111);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL static cyc=%0d got=%b want=%b", i, leds, exp_v);
            end
        end
    endtask

    task automatic test_blink();
        mode = 2'd1;
        for (int m = 0; m < 24; m++) begin
            exp_q.push_back(((m / 4) % 2 == 0) ? 5'b11111 : 5'b00000);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL blink m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
    endtask

    task automatic test_chase();
        mode = 2'd2;
        for (int m = 0; m < 28; m++) begin
            exp_q.push_back(5'b00001 << ((m / 4) % 5));
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL chase m=%0d got=%b want=%b", m, leds, exp_v);
            end
            total++;
            if ($countones(leds) != 1) begin
                bad++;
                $display("FAIL chase_onehot m=%0d got=%b want=one_hot", m, leds);
            end
        end
    endtask

    task automatic test_bounce();
        int led4_cnt;
        led4_cnt = 0;
        mode = 2'd3;
        for (int m = 0; m < 40; m++) begin
            exp_q.push_back(5'b00001 << bounce_seq[(m / 4) % 8]);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL bounce m=%0d got=%b want=%b", m, leds, exp_v);
            end
            if (m < 32 && LED4 === 1'b1) led4_cnt++;
        end
        total++;
        if (led4_cnt != 4) begin
            bad++;
            $display("FAIL bounce_led4_cycles got=%0d want=4", led4_cnt);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'd2;
        for (int m = 0; m <= 12; m++) begin
            exp_q.push_back(5'b00001 << ((m / 4) % 5));
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL b2b_lead m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
        // At pos=3: flip to blink for one edge, then back to chase.
        mode = 2'd1;
        exp_q.push_back(5'b11111);
        cycle();
        exp_v = exp_q.pop_front();
        total++;
        if (leds !== exp_v) begin
            bad++;
            $display("FAIL b2b_blink got=%b want=%b", leds, exp_v);
        end
        mode = 2'd2;
        for (int m = 0; m < 9; m++) begin
            exp_q.push_back(5'b00001 << ((m / 4) % 5));
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL b2b_restart m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_bounce();
        mode = 2'd3;
        for (int m = 0; m <= 24; m++) begin
            exp_q.push_back(5'b00001 << bounce_seq[(m / 4) % 8]);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL rmb_lead m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
        // pos=2 heading down; one reset edge with mode held at bounce.
        rst = 1'b1;
        exp_q.push_back(5'b11111);
        cycle();
        exp_v = exp_q.pop_front();
        total++;
        if (leds !== exp_v) begin
            bad++;
            $display("FAIL rmb_reset got=%b want=%b", leds, exp_v);
        end
        rst = 1'b0;
        for (int m = 0; m < 20; m++) begin
            exp_q.push_back(5'b00001 << bounce_seq[(m / 4) % 8]);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL rmb_restart m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
    endtask

    task automatic test_back_to_static();
        mode = 2'd0;
        for (int m = 0; m < 10; m++) begin
            exp_q.push_back(5'b11111);
            cycle();
            exp_v = exp_q.pop_front();
            total++;
            if (leds !== exp_v) begin
                bad++;
                $display("FAIL static_return m=%0d got=%b want=%b", m, leds, exp_v);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        mode = 2'd0;
        #2;
        test_reset();
        test_blink();
        test_chase();
        test_bounce();
        test_back_to_back();
        test_reset_mid_bounce();
        test_back_to_static();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
